// File: rtl/offchip_mem_bridge.sv
// Bridges single-word memory requests onto a 48-bit SPI SRAM frame (mode 0).
// Each frame is 8-bit command, 24-bit byte address and 16 data bits, sent MSB first.
module offchip_mem_bridge #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        memory_we,
  input  logic [15:0] address_in,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_valid,
  output logic        mem_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] CMD_WR   = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h03;

  state_t      state, state_nxt;
  logic [47:0] shift_q, shift_d;
  logic [5:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  div_cnt, div_cnt_d;
  logic        is_read, is_read_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] rdata_d;
  logic        rd_valid_d, mem_ready_d, cs_n_d, sck_d, mosi_d;
  logic        div_end;
  logic [47:0] new_frame;

  assign new_frame = {memory_we ? CMD_WR : CMD_RD, 7'b0, address_in, 1'b0,
                      memory_we ? wdata : 16'h0000};
  assign div_end   = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      is_read   <= 1'b0;
      rx_q      <= '0;
      rdata     <= '0;
      rd_valid  <= 1'b0;
      mem_ready <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_d;
      bit_cnt   <= bit_cnt_d;
      div_cnt   <= div_cnt_d;
      is_read   <= is_read_d;
      rx_q      <= rx_d;
      rdata     <= rdata_d;
      rd_valid  <= rd_valid_d;
      mem_ready <= mem_ready_d;
      spi_cs_n  <= cs_n_d;
      spi_sck   <= sck_d;
      spi_mosi  <= mosi_d;
    end
  end

  // Outputs are registered so SCK/MOSI/CS change on clean clk edges;
  // bit 47 is presented on acceptance and the rest shift out from shift_q.
  always_comb begin
    state_nxt   = state;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt;
    div_cnt_d   = div_cnt;
    is_read_d   = is_read;
    rx_d        = rx_q;
    rdata_d     = rdata;
    rd_valid_d  = 1'b0;
    mem_ready_d = mem_ready;
    cs_n_d      = spi_cs_n;
    sck_d       = spi_sck;
    mosi_d      = spi_mosi;

    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nxt   = CMD;
          shift_d     = {new_frame[46:0], 1'b0};
          mosi_d      = new_frame[47];
          cs_n_d      = 1'b0;
          sck_d       = 1'b0;
          mem_ready_d = 1'b0;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          is_read_d   = ~memory_we;
        end
      end

      CMD, ADDR, DATA: begin
        if (!div_end) begin
          div_cnt_d = div_cnt + 8'd1;
        end else begin
          div_cnt_d = '0;
          if (!spi_sck) begin
            sck_d = 1'b1;
            if (state == DATA) rx_d = {rx_q[14:0], spi_miso};
          end else begin
            sck_d = 1'b0;
            if (bit_cnt == 6'd47) begin
              state_nxt  = GAP;
              cs_n_d     = 1'b1;
              mosi_d     = 1'b0;
              bit_cnt_d  = '0;
              rd_valid_d = is_read;
              if (is_read) rdata_d = rx_q;
            end else begin
              bit_cnt_d = bit_cnt + 6'd1;
              mosi_d    = shift_q[47];
              shift_d   = {shift_q[46:0], 1'b0};
              if (bit_cnt == 6'd7)  state_nxt = ADDR;
              if (bit_cnt == 6'd31) state_nxt = DATA;
            end
          end
        end
      end

      GAP: begin
        if (div_end) begin
          state_nxt   = IDLE;
          mem_ready_d = 1'b1;
          div_cnt_d   = '0;
        end else begin
          div_cnt_d = div_cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_offchip_mem_bridge.sv
// Three bridges (CLK_DIV = 1, 2, 3) against a shared behavioural SPI SRAM;
// frames and read data are scoreboarded against bench-written expectations.
module tb_offchip_mem_bridge;

  localparam int NI     = 3;
  localparam int MAXOBS = 64;

  typedef struct {
    int          inst;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [47:0] frame;
    logic [15:0] rd;
  } vec_t;

  typedef struct {
    int          inst;
    logic [47:0] frame;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        mem_req    [NI];
  logic        memory_we  [NI];
  logic [15:0] address_in [NI];
  logic [15:0] wdata      [NI];
  logic [15:0] rdata      [NI];
  logic        rd_valid   [NI];
  logic        mem_ready  [NI];
  logic        spi_cs_n   [NI];
  logic        spi_sck    [NI];
  logic        spi_mosi   [NI];
  logic        miso       [NI] = '{1'b0, 1'b0, 1'b0};

  int tests = 0;
  int fails = 0;

  exp_t        exp_frames [$];
  logic [15:0] exp_reads  [$];
  logic [15:0] last_rdata [NI] = '{16'h0, 16'h0, 16'h0};

  // SRAM model state: only the monitor process writes these
  logic [15:0] sram [logic [15:0]];
  logic [47:0] obs_frame [MAXOBS];
  int          obs_inst  [MAXOBS];
  int          obs_n     = 0;
  int          partial_n = 0;
  int          obs_rd    = 0;
  logic        prev_cs  [NI] = '{1'b1, 1'b1, 1'b1};
  logic        prev_sck [NI] = '{1'b0, 1'b0, 1'b0};
  int          nbits    [NI] = '{0, 0, 0};
  logic [47:0] sh       [NI] = '{48'h0, 48'h0, 48'h0};
  logic [7:0]  cmd      [NI] = '{8'h0, 8'h0, 8'h0};
  logic [15:0] rdw      [NI] = '{16'h0, 16'h0, 16'h0};

  for (genvar g = 0; g < NI; g++) begin : g_inst
    offchip_mem_bridge #(.CLK_DIV(g + 1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_req    (mem_req[g]),
      .memory_we  (memory_we[g]),
      .address_in (address_in[g]),
      .wdata      (wdata[g]),
      .rdata      (rdata[g]),
      .rd_valid   (rd_valid[g]),
      .mem_ready  (mem_ready[g]),
      .spi_cs_n   (spi_cs_n[g]),
      .spi_sck    (spi_sck[g]),
      .spi_mosi   (spi_mosi[g]),
      .spi_miso   (miso[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] sram_read(input logic [15:0] a);
    if (sram.exists(a)) return sram[a];
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Mode-0 SRAM: capture MOSI on SCK rise, present MISO while SCK is low
  always @(spi_cs_n[0] or spi_cs_n[1] or spi_cs_n[2] or
           spi_sck[0] or spi_sck[1] or spi_sck[2]) begin
    for (int i = 0; i < NI; i++) begin
      if (spi_cs_n[i] !== prev_cs[i]) begin
        if (spi_cs_n[i] === 1'b0) begin
          nbits[i] = 0;
          sh[i]    = '0;
          cmd[i]   = '0;
        end else if (nbits[i] == 48) begin
          if (obs_n < MAXOBS) begin
            obs_frame[obs_n] = sh[i];
            obs_inst[obs_n]  = i;
          end
          obs_n++;
          if (sh[i][47:40] == 8'h02) sram[sh[i][32:17]] = sh[i][15:0];
          nbits[i] = 0;
        end else if (nbits[i] > 0) begin
          partial_n++;
          nbits[i] = 0;
        end
      end else if (spi_cs_n[i] === 1'b0 && spi_sck[i] !== prev_sck[i] && spi_sck[i] === 1'b1) begin
        sh[i] = {sh[i][46:0], spi_mosi[i]};
        nbits[i]++;
        if (nbits[i] == 32) begin
          cmd[i] = sh[i][31:24];
          rdw[i] = sram_read(sh[i][16:1]);
        end
      end
      if (spi_cs_n[i] === 1'b0 && spi_sck[i] === 1'b0)
        miso[i] = (cmd[i] == 8'h03 && nbits[i] >= 32 && nbits[i] < 48) ? rdw[i][47 - nbits[i]] : 1'b0;
      prev_cs[i]  = spi_cs_n[i];
      prev_sck[i] = spi_sck[i];
    end
  end

  task automatic compare_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic we, input logic [15:0] addr,
                                input logic [15:0] wd, input logic [47:0] frame,
                                input logic [15:0] rd);
    exp_t e;
    compare_val("ready_before_req", 64'(mem_ready[inst]), 64'd1);
    e.inst  = inst;
    e.frame = frame;
    exp_frames.push_back(e);
    if (!we) exp_reads.push_back(rd);
    mem_req[inst]    = 1'b1;
    memory_we[inst]  = we;
    address_in[inst] = addr;
    wdata[inst]      = wd;
    @(posedge clk);
    #1 mem_req[inst] = 1'b0;
  endtask

  // Walks one frame cycle by cycle; returns at the first ready cycle
  task automatic check_output(input int inst, input logic we, input int busy_j, output int cs_high);
    int d, fl, rl, cs_bad, rdy_bad, sck_bad, rdv_cnt, rdv_j, run;
    logic last_sck;
    logic [15:0] er;
    d = inst + 1;
    fl = 96 * d;
    rl = 97 * d;
    cs_bad = 0; rdy_bad = 0; sck_bad = 0; rdv_cnt = 0; rdv_j = -1; run = 0;
    last_sck = 1'b0;
    cs_high = 0;
    for (int j = 0; j <= rl; j++) begin
      @(negedge clk);
      if (j == busy_j) begin
        mem_req[inst]    = 1'b1;
        memory_we[inst]  = ~we;
        address_in[inst] = 16'hDEAD;
        wdata[inst]      = 16'h7777;
      end else if (j == busy_j + 1) begin
        mem_req[inst] = 1'b0;
      end
      if ((j < fl) ? (spi_cs_n[inst] !== 1'b0) : (spi_cs_n[inst] !== 1'b1)) cs_bad++;
      if (j >= fl && spi_cs_n[inst] === 1'b1) cs_high++;
      if ((j < rl) ? (mem_ready[inst] !== 1'b0) : (mem_ready[inst] !== 1'b1)) rdy_bad++;
      if (j == 0) begin
        run = 1;
        last_sck = spi_sck[inst];
        if (spi_sck[inst] !== 1'b0) sck_bad++;
      end else if (j < fl) begin
        if (spi_sck[inst] === last_sck) run++;
        else begin
          if (run != d) sck_bad++;
          run = 1;
          last_sck = spi_sck[inst];
        end
      end else if (j == fl) begin
        if (run != d || spi_sck[inst] !== 1'b0) sck_bad++;
      end
      if (rd_valid[inst] === 1'b1) begin
        rdv_cnt++;
        rdv_j = j;
        if (exp_reads.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL rd_valid_unexpected: got rdata %0h, expected no pulse", rdata[inst]);
        end else begin
          er = exp_reads.pop_front();
          compare_val("rdata", 64'(rdata[inst]), 64'(er));
          last_rdata[inst] = er;
        end
      end
    end
    compare_val("cs_n_window", 64'(cs_bad), 64'd0);
    compare_val("mem_ready_window", 64'(rdy_bad), 64'd0);
    compare_val("sck_phase", 64'(sck_bad), 64'd0);
    compare_val("rd_valid_pulse", {32'(rdv_cnt), 32'(rdv_j)},
                {32'(we ? 0 : 1), 32'(we ? -1 : fl)});
    if (we) compare_val("rdata_hold", 64'(rdata[inst]), 64'(last_rdata[inst]));
  endtask

  task automatic drain_frames();
    exp_t e;
    while (obs_rd < obs_n) begin
      if (exp_frames.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL frame_unexpected: got %0h on inst %0d, expected none",
                 obs_frame[obs_rd], obs_inst[obs_rd]);
      end else begin
        e = exp_frames.pop_front();
        compare_val("mosi_frame", {obs_inst[obs_rd][15:0], obs_frame[obs_rd]},
                    {e.inst[15:0], e.frame});
      end
      obs_rd++;
    end
  endtask

  initial begin
    vec_t vecs [6];
    int hi, obs0, part0, dummy, stray;

    vecs[0] = '{1, 1'b1, 16'h0010, 16'hA5C3, 48'h02_000020_A5C3, 16'h0000};
    vecs[1] = '{0, 1'b0, 16'h1234, 16'h0000, 48'h03_002468_0000, 16'hBEEF};
    vecs[2] = '{2, 1'b0, 16'hFFFF, 16'h0000, 48'h03_01FFFE_0000, 16'hA5A5};
    vecs[3] = '{2, 1'b1, 16'hFFFF, 16'h0F0F, 48'h02_01FFFE_0F0F, 16'h0000};
    vecs[4] = '{1, 1'b0, 16'h0010, 16'h0000, 48'h03_000020_0000, 16'hA5C3};
    vecs[5] = '{0, 1'b1, 16'h8001, 16'h3C96, 48'h02_010002_3C96, 16'h0000};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      mem_req[i] = 1'b0; memory_we[i] = 1'b0; address_in[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      compare_val("reset_state", {spi_cs_n[i], spi_sck[i], spi_mosi[i], rdata[i], rd_valid[i], mem_ready[i]},
                  {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] table vectors");
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].inst, vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].frame, vecs[v].rd);
      check_output(vecs[v].inst, vecs[v].we, -1, dummy);
      drain_frames();
      repeat (3) @(negedge clk);
    end

    $display("[TB] busy request ignored");
    obs0 = obs_n;
    apply_stimulus(1, 1'b1, 16'h0100, 16'h1111, 48'h02_000200_1111, 16'h0);
    check_output(1, 1'b1, 40, dummy);
    stray = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (spi_cs_n[1] !== 1'b1 || mem_ready[1] !== 1'b1) stray++;
    end
    compare_val("busy_no_restart", 64'(stray), 64'd0);
    compare_val("busy_frame_count", 64'(obs_n - obs0), 64'd1);
    drain_frames();

    $display("[TB] back-to-back write then read");
    apply_stimulus(0, 1'b1, 16'h0042, 16'hCAFE, 48'h02_000084_CAFE, 16'h0);
    check_output(0, 1'b1, -1, hi);
    apply_stimulus(0, 1'b0, 16'h0042, 16'h0000, 48'h03_000084_0000, 16'hCAFE);
    check_output(0, 1'b0, -1, dummy);
    compare_val("b2b_cs_high", 64'(hi), 64'd2);
    drain_frames();
    repeat (3) @(negedge clk);

    $display("[TB] reset during read");
    obs0 = obs_n;
    part0 = partial_n;
    mem_req[1] = 1'b1; memory_we[1] = 1'b0; address_in[1] = 16'h1234; wdata[1] = '0;
    @(posedge clk);
    #1 mem_req[1] = 1'b0;
    repeat (82) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compare_val("reset_async", {spi_cs_n[1], spi_sck[1], spi_mosi[1], rdata[1], rd_valid[1], mem_ready[1]},
                {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    compare_val("reset_partial", 64'(partial_n - part0), 64'd1);
    compare_val("reset_no_frame", 64'(obs_n - obs0), 64'd0);
    for (int i = 0; i < NI; i++) last_rdata[i] = 16'h0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    apply_stimulus(1, 1'b0, 16'h1234, 16'h0000, 48'h03_002468_0000, 16'hBEEF);
    check_output(1, 1'b0, -1, dummy);
    drain_frames();

    repeat (4) @(negedge clk);
    drain_frames();
    compare_val("frames_pending", 64'(exp_frames.size()), 64'd0);
    compare_val("reads_pending", 64'(exp_reads.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/offchip_mem_bridge.md
OFFCHIP_MEM_BRIDGE -- requirements
Module: offchip_mem_bridge

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the SCK half-period in clk cycles; legal values are 1 to 255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port mem_req, input, 1 bit: transaction request from the memory controller.
REQ-005 The block SHALL have port memory_we, input, 1 bit: 1 means write, 0 means read; sampled with mem_req.
REQ-006 The block SHALL have port address_in, input, 16 bits: word address; sampled with mem_req.
REQ-007 The block SHALL have port wdata, input, 16 bits: write data; sampled with mem_req.
REQ-008 The block SHALL have port rdata, output, 16 bits: last completed read word.
REQ-009 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse when rdata updates.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: idle, able to accept a request; this signal drives the controller's off_chip_mem_ready.
REQ-011 The block SHALL have port spi_cs_n, output, 1 bit: SRAM chip select, active low.
REQ-012 The block SHALL have port spi_sck, output, 1 bit: SPI clock, mode 0.
REQ-013 The block SHALL have port spi_mosi, output, 1 bit: serial data to the SRAM.
REQ-014 The block SHALL have port spi_miso, input, 1 bit: serial data from the SRAM.

Function
REQ-015 Acceptance SHALL occur on a clk edge T where mem_req=1 and mem_ready=1; memory_we, address_in and wdata SHALL be latched at T.
REQ-016 mem_req asserted while mem_ready=0 SHALL be ignored; requests SHALL NOT be queued.
REQ-017 Every transaction SHALL be one 48-bit frame, MSB first, in this order:
- 8-bit command: 0x02 for write, 0x03 for read.
- 24-bit byte address {7'b0, address_in, 1'b0}.
- 16 data bits.
REQ-018 For a write, the data bits SHALL be wdata[15:0] and spi_miso SHALL be ignored.
REQ-019 For a read, spi_mosi SHALL be 0 during the data bits, and the 16 spi_miso samples SHALL be shifted into rdata MSB first.
REQ-020 The state machine SHALL have states IDLE, CMD, ADDR, DATA and GAP.
REQ-021 State transitions SHALL be:
- IDLE to CMD on acceptance.
- CMD to ADDR after 8 bits.
- ADDR to DATA after 24 bits.
- DATA to GAP after 16 bits.
- GAP to IDLE after CLK_DIV cycles.
REQ-022 At T+1 the block SHALL drive spi_cs_n=0, spi_sck=0 and spi_mosi=frame bit 47.
REQ-023 Each bit SHALL last 2*CLK_DIV cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-024 spi_mosi SHALL change only on the edge that drives SCK low; spi_miso SHALL be sampled on the clk edge that drives SCK 1.
REQ-025 At T+1+96*CLK_DIV the block SHALL drive spi_cs_n=1 and spi_sck=0, and SHALL enter GAP.
REQ-026 For a read, rdata SHALL update and rd_valid SHALL be 1 for exactly one cycle, both at the same edge as REQ-025.
REQ-027 mem_ready SHALL be 0 from T+1 until it returns to 1 at T+1+97*CLK_DIV; in IDLE, mem_ready SHALL be 1.
REQ-028 A request at the first IDLE cycle SHALL be accepted, so back-to-back frames have a spi_cs_n high time of exactly CLK_DIV+1 cycles.
REQ-029 Writes SHALL NOT modify rdata or pulse rd_valid.
REQ-030 Bit and divider counters SHALL saturate or clear at frame end; no counter SHALL wrap mid-frame.
REQ-031 address_in=16'hFFFF SHALL map to byte address 24'h01FFFE; no overflow handling is required.

Reset
REQ-032 While rst_n=0, asynchronously: spi_cs_n=1, spi_sck=0, spi_mosi=0, rdata=0, rd_valid=0, mem_ready=1, state=IDLE.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with spi_cs_n going high without waiting for clk.
REQ-034 After reset release, the first request SHALL start a complete new frame.

Verification
REQ-035 Write test: CLK_DIV=2; write, address 16'h0010, wdata 16'hA5C3 -> MOSI frame 0x02,0x000020,0xA5C3; cs_n low for 192 cycles; mem_ready high at T+195.
REQ-036 Read test: CLK_DIV=1; read, address 16'h1234; SRAM model returns 16'hBEEF -> MOSI 0x03,0x002468,0x0000; rdata=16'hBEEF with rd_valid one cycle at T+97.
REQ-037 Busy test: second mem_req pulsed mid-frame -> ignored; frame unchanged and exactly one transaction observed.
REQ-038 Back-to-back test: write then read issued at the first ready cycle -> cs_n high for CLK_DIV+1 cycles between frames; read returns the written word.
REQ-039 Reset test: rst_n pulsed low at bit 20 of a read -> cs_n=1 asynchronously, rdata=0, no rd_valid; the next read completes normally.
REQ-040 Boundary test: address 16'hFFFF, CLK_DIV=3 -> address field 0x01FFFE; SCK high and low phases each 3 cycles.
